// File: rtl/multi_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : multi_debounce_pulse
// Description : Multi-channel button debouncer with edge pulses.  All logic
//               runs on clk.  A divided clock-enable ("tick") paces the
//               stability counters, so every pulse is exactly one clk wide.
//               Optional auto-repeat is enabled by defining the macro
//               AUTOREPEAT_EN.
// Ports       :
//   clk          in   1         system clock, posedge
//   reset_n      in   1         asynchronous active-low reset
//   button       in   CHANNELS  raw asynchronous buttons, active high
//   tick         out  1         one-clk debounce-tick strobe
//   level        out  CHANNELS  debounced button state
//   rise         out  CHANNELS  one-clk pulse on 0->1 (or on auto-repeat)
//   fall         out  CHANNELS  one-clk pulse on 1->0
//   repeat_flag  out  CHANNELS  one-clk pulse marking an auto-repeat rise
//                               (constant 0 without AUTOREPEAT_EN)
// Revision    : 1.0  initial release
// ============================================================================
module multi_debounce_pulse #(
  parameter int CHANNELS     = 4,
  parameter int CLK_DIV      = 124,
  parameter int STABLE_TICKS = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int HOLD_TICKS   = 250,
  parameter int REPEAT_TICKS = 50
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] button,
  output logic                tick,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] repeat_flag
);

  localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_CNT_W = $clog2(STABLE_TICKS + 1);

  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_TICKS - 1);

`ifdef AUTOREPEAT_EN
  localparam int c_RCNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int c_RCNT_W   = $clog2(c_RCNT_MAX + 1);

  localparam logic [c_RCNT_W-1:0] c_HOLD   = c_RCNT_W'(HOLD_TICKS);
  localparam logic [c_RCNT_W-1:0] c_REPEAT = c_RCNT_W'(REPEAT_TICKS);
`endif

  // Elaboration-time sanity check of the configuration.
  if (CLK_DIV < 2 || STABLE_TICKS < 1 || SYNC_STAGES < 2 ||
      HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
    $error("multi_debounce_pulse: illegal parameter combination");
  end

  // --------------------------------------------------------------------------
  // Tick divider.  r_tick is registered, so it is high in the cycle after
  // r_div reaches CLK_DIV-1; the first tick lands CLK_DIV cycles after reset.
  // --------------------------------------------------------------------------
  logic [c_DIV_W-1:0] r_div;
  logic               r_tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_div == c_DIV_LAST);
      if (r_div == c_DIV_LAST) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign tick = r_tick;

  // --------------------------------------------------------------------------
  // Per-channel synchroniser, stability counter and pulse generation.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;
    logic                   w_qual;
    logic                   w_rep_now;

    assign w_s = r_sync[SYNC_STAGES-1];

    // The synchronised input has disagreed with level for STABLE_TICKS
    // consecutive ticks: level flips on this edge.
    assign w_qual = r_tick && (w_s != r_level) && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sync  <= '0;
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], button[i]};
        // Pulses default low so each assertion lasts exactly one clk.
        r_rise <= (w_qual && w_s) || w_rep_now;
        r_fall <= w_qual && !w_s;
        if (r_tick) begin
          if (w_s == r_level) begin
            r_cnt <= '0;
          end else if (r_cnt == c_CNT_LAST) begin
            r_level <= w_s;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end

    assign level[i] = r_level;
    assign rise[i]  = r_rise;
    assign fall[i]  = r_fall;

`ifdef AUTOREPEAT_EN
    // Auto-repeat: r_rcnt counts ticks while level is high.  r_held marks
    // that the initial HOLD_TICKS interval has elapsed, after which the
    // shorter REPEAT_TICKS interval applies.
    logic [c_RCNT_W-1:0] r_rcnt;
    logic [c_RCNT_W-1:0] w_rcnt_inc;
    logic [c_RCNT_W-1:0] w_rep_target;
    logic                r_held;
    logic                r_rep;

    assign w_rcnt_inc   = r_rcnt + 1'b1;
    assign w_rep_target = r_held ? c_REPEAT : c_HOLD;

    // A qualifying fall on the same tick suppresses the repeat.
    assign w_rep_now = r_tick && r_level && !w_qual && (w_rcnt_inc == w_rep_target);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_rcnt <= '0;
        r_held <= 1'b0;
        r_rep  <= 1'b0;
      end else begin
        r_rep <= w_rep_now;
        // w_qual covers both the rising edge (level still 0 here) and a fall.
        if (!r_level || w_qual) begin
          r_rcnt <= '0;
          r_held <= 1'b0;
        end else if (w_rep_now) begin
          r_rcnt <= '0;
          r_held <= 1'b1;
        end else if (r_tick) begin
          r_rcnt <= w_rcnt_inc;
        end
      end
    end

    assign repeat_flag[i] = r_rep;
`else
    assign w_rep_now      = 1'b0;
    assign repeat_flag[i] = 1'b0;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_debounce_pulse
// Description : Scoreboard bench for multi_debounce_pulse with CHANNELS=2,
//               CLK_DIV=4, STABLE_TICKS=3, SYNC_STAGES=2, HOLD_TICKS=5,
//               REPEAT_TICKS=2.  Stimulus pushes expected pulse events with
//               a cycle window; a negedge monitor pops them whenever the DUT
//               pulses rise/fall/repeat_flag, and also checks the tick cadence.
// Revision    : 1.0  initial release
// ============================================================================
module tb_multi_debounce_pulse;

  localparam int CH = 2;

  logic          clk;
  logic          reset_n;
  logic [CH-1:0] button;
  logic          tick;
  logic [CH-1:0] level;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] repeat_flag;

  multi_debounce_pulse #(
    .CHANNELS    (CH),
    .CLK_DIV     (4),
    .STABLE_TICKS(3),
    .SYNC_STAGES (2),
    .HOLD_TICKS  (5),
    .REPEAT_TICKS(2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .button     (button),
    .tick       (tick),
    .level      (level),
    .rise       (rise),
    .fall       (fall),
    .repeat_flag(repeat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle count since reset release: at the negedge after edge k, cyc == k.
  int cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  typedef struct {
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] rep;
    int            lo;
    int            hi;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input logic [CH-1:0] r, input logic [CH-1:0] f,
                      input logic [CH-1:0] p, input int lo, input int hi,
                      input string name);
    sb.push_back('{r, f, p, lo, hi, name});
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  logic mon_exp_tick;

  always @(negedge clk) begin
    if (reset_n) begin
      mon_exp_tick = (cyc % 4 == 0) && (cyc != 0);
      checks++;
      if (tick !== mon_exp_tick) begin
        failures++;
        $display("FAIL tick_cadence cyc=%0d got=%b want=%b", cyc, tick, mon_exp_tick);
      end
      if (sb.size() > 0 && cyc > sb[0].hi) begin
        checks++;
        failures++;
        $display("FAIL %s timeout cyc=%0d got=no_pulse want=pulse_by_%0d",
                 sb[0].name, cyc, sb[0].hi);
        sb.delete(0);
      end
      if ((rise | fall | repeat_flag) != '0) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse cyc=%0d got rise=%b fall=%b rep=%b want=none",
                   cyc, rise, fall, repeat_flag);
        end else begin
          mon_e = sb.pop_front();
          if (rise !== mon_e.rise || fall !== mon_e.fall || repeat_flag !== mon_e.rep ||
              cyc < mon_e.lo || cyc > mon_e.hi) begin
            failures++;
            $display("FAIL %s got cyc=%0d rise=%b fall=%b rep=%b want cyc=%0d..%0d rise=%b fall=%b rep=%b",
                     mon_e.name, cyc, rise, fall, repeat_flag,
                     mon_e.lo, mon_e.hi, mon_e.rise, mon_e.fall, mon_e.rep);
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic wait_level(input logic [CH-1:0] want, input string name);
    int n = 0;
    while (level !== want && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (level !== want) begin
      checks++;
      failures++;
      $display("FAIL %s wait_level got=%b want=%b", name, level, want);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s drain got=%0d_pending want=0", name, sb.size());
      sb.delete();
    end
    repeat (10) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int c;
  int q;

  initial begin
    button  = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;

    // Idle: tick cadence checked by the monitor, no pulses, level low.
    while (cyc < 100) @(negedge clk);
    chk("idle_level", 32'(level), 32'h0);

    // Single channel press: rise within the latency window, channel 1 quiet.
    c = cyc;
    button = 2'b01;
    push(2'b01, 2'b00, 2'b00, c + 11, c + 15, "press0_rise");
    wait_level(2'b01, "press0");
    chk("press0_level1", 32'(level[1]), 32'h0);
`ifndef AUTOREPEAT_EN
    repeat (60) @(negedge clk);
    chk("hold0_level", 32'(level), 32'h1);
`endif
    c = cyc;
    button = 2'b00;
    push(2'b00, 2'b01, 2'b00, c + 11, c + 15, "release0_fall");
    drain("press0");
    chk("release0_level", 32'(level), 32'h0);

    // Short glitches: one tick high, two ticks low, ten times.
    for (int k = 0; k < 10; k++) begin
      button = 2'b01;
      repeat (4) @(negedge clk);
      button = 2'b00;
      repeat (8) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("glitch_level", 32'(level), 32'h0);

    // Both channels together.
    c = cyc;
    button = 2'b11;
    push(2'b11, 2'b00, 2'b00, c + 11, c + 15, "both_rise");
    wait_level(2'b11, "both");
    c = cyc;
    button = 2'b00;
    push(2'b00, 2'b11, 2'b00, c + 11, c + 15, "both_fall");
    drain("both");
    chk("both_level", 32'(level), 32'h0);

    // Reset in the middle of qualification.
    button = 2'b01;
    repeat (8) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 chk("reset_outputs", {25'h0, tick, level, rise, fall, repeat_flag}, 32'h0);
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    push(2'b01, 2'b00, 2'b00, 11, 15, "requal_rise");
    wait_level(2'b01, "requal");
    c = cyc;
    button = 2'b00;
    push(2'b00, 2'b01, 2'b00, c + 11, c + 15, "requal_fall");
    drain("requal");
    chk("requal_level", 32'(level), 32'h0);

`ifdef AUTOREPEAT_EN
    // Auto-repeat: press aligned so qualification lands at c+13.
    while (cyc % 4 != 0) @(negedge clk);
    c = cyc;
    q = c + 13;
    button = 2'b01;
    push(2'b01, 2'b00, 2'b00, q, q, "ar_first_rise");
    for (int k = 0; k <= 8; k++) begin
      push(2'b01, 2'b00, 2'b01, q + 20 + 8 * k, q + 20 + 8 * k, "ar_repeat");
    end
    while (cyc < q + 80) @(negedge clk);
    button = 2'b00;
    // Fall at q+92 also suppresses the repeat due on that tick.
    push(2'b00, 2'b01, 2'b00, q + 92, q + 92, "ar_fall");
    drain("autorepeat");
    chk("ar_level", 32'(level), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=running want=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
`default_nettype wire
